btb_param: RTL and testbench

Parametrised branch target buffer for the RV32IM pipeline, the successor of the fixed-size BTB. Provides a same-cycle prediction (hit, predicted-taken, target) for the fetch-stage PC and is trained by resolved branches/jumps from the execute stage. Adds configurable depth and saturating-counter width, a bulk invalidate, and saturating lookup/hit performance counters.

---
 rtl/btb_param_if.sv | 31 +++
 rtl/btb_param.sv | 104 ++++++++++
 tb/tb_btb_param.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/btb_param_if.sv
// Fetch/execute-side bundle of the parametrised branch target buffer.
// The master drives lookup, training and control; the slave answers with prediction and perf counts.
interface btb_param_if #(
    parameter int PERF_WIDTH = 32
);
    logic [31:0]           pc;
    logic                  lookup_en;
    logic                  update;
    logic [31:0]           update_pc;
    logic                  update_taken;
    logic [31:0]           update_target;
    logic                  flush_all;
    logic                  perf_clear;
    logic [31:0]           target_pc;
    logic                  valid;
    logic                  predicted_taken;
    logic [PERF_WIDTH-1:0] lookup_count;
    logic [PERF_WIDTH-1:0] hit_count;

    modport master (
        output pc, lookup_en, update, update_pc, update_taken, update_target,
               flush_all, perf_clear,
        input  target_pc, valid, predicted_taken, lookup_count, hit_count
    );

    modport slave (
        input  pc, lookup_en, update, update_pc, update_taken, update_target,
               flush_all, perf_clear,
        output target_pc, valid, predicted_taken, lookup_count, hit_count
    );
endinterface

// File: rtl/btb_param.sv
// Direct-mapped branch target buffer with saturating prediction counters.
// Same-cycle lookup from registered state; trained one edge after execute resolves.
module btb_param #(
    parameter int ENTRIES    = 16,
    parameter int CTR_BITS   = 2,
    parameter int PERF_WIDTH = 32
) (
    input logic       clk,
    input logic       rst,
    btb_param_if.slave bus
);
    localparam int IDX   = $clog2(ENTRIES);
    localparam int TAG_W = 30 - IDX;
    localparam logic [CTR_BITS-1:0]   CTR_MAX  = '1;
    localparam logic [CTR_BITS-1:0]   CTR_WEAK = CTR_BITS'(1 << (CTR_BITS - 1));
    localparam logic [PERF_WIDTH-1:0] PERF_MAX = '1;

    logic [ENTRIES-1:0]  valid_q, valid_d;
    logic [TAG_W-1:0]    tag_q    [ENTRIES];
    logic [31:0]         target_q [ENTRIES];
    logic [CTR_BITS-1:0] ctr_q    [ENTRIES];

    logic [PERF_WIDTH-1:0] lookup_count_q, lookup_count_d;
    logic [PERF_WIDTH-1:0] hit_count_q, hit_count_d;

    logic [IDX-1:0]      lu_idx, up_idx;
    logic [TAG_W-1:0]    lu_tag, up_tag;
    logic                lu_hit, up_hit, wr_en;
    logic [CTR_BITS-1:0] ctr_d;

    // Byte offset bits never participate in indexing or tagging.
    logic unused_offset;
    assign unused_offset = ^{bus.pc[1:0], bus.update_pc[1:0]};

    assign lu_idx = bus.pc[IDX+1:2];
    assign lu_tag = bus.pc[31:IDX+2];
    assign up_idx = bus.update_pc[IDX+1:2];
    assign up_tag = bus.update_pc[31:IDX+2];

    assign lu_hit = valid_q[lu_idx] && (tag_q[lu_idx] == lu_tag);
    assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

    assign bus.valid           = lu_hit;
    assign bus.predicted_taken = lu_hit && ctr_q[lu_idx][CTR_BITS-1];
    assign bus.target_pc       = lu_hit ? target_q[lu_idx] : 32'h0;
    assign bus.lookup_count    = lookup_count_q;
    assign bus.hit_count       = hit_count_q;

    // A not-taken miss neither allocates nor evicts; flush discards any update.
    assign wr_en = bus.update && !bus.flush_all && (up_hit || bus.update_taken);

    always_comb begin
        ctr_d = CTR_WEAK;
        if (up_hit) begin
            ctr_d = ctr_q[up_idx];
            if (bus.update_taken) begin
                if (ctr_q[up_idx] != CTR_MAX) ctr_d = ctr_q[up_idx] + 1'b1;
            end else begin
                if (ctr_q[up_idx] != '0) ctr_d = ctr_q[up_idx] - 1'b1;
            end
        end
    end

    always_comb begin
        valid_d = valid_q;
        if (bus.flush_all)
            valid_d = '0;
        else if (wr_en)
            valid_d[up_idx] = 1'b1;
    end

    always_comb begin
        lookup_count_d = lookup_count_q;
        hit_count_d    = hit_count_q;
        if (bus.perf_clear) begin
            lookup_count_d = '0;
            hit_count_d    = '0;
        end else if (bus.lookup_en) begin
            if (lookup_count_q != PERF_MAX) lookup_count_d = lookup_count_q + 1'b1;
            if (lu_hit && hit_count_q != PERF_MAX) hit_count_d = hit_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q        <= '0;
            lookup_count_q <= '0;
            hit_count_q    <= '0;
        end else begin
            valid_q        <= valid_d;
            lookup_count_q <= lookup_count_d;
            hit_count_q    <= hit_count_d;
        end
    end

    // Payload fields are only meaningful behind a valid bit, so they carry no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_q[up_idx] <= up_tag;
            ctr_q[up_idx] <= ctr_d;
            if (bus.update_taken) target_q[up_idx] <= bus.update_target;
        end
    end
endmodule

// File: tb/tb_btb_param.sv
// Directed bench for btb_param (16 entries, 2-bit counters, 8-bit perf counters).
module tb_btb_param;
    localparam int PW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    btb_param_if #(.PERF_WIDTH(PW)) bif ();

    btb_param #(.ENTRIES(16), .CTR_BITS(2), .PERF_WIDTH(PW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    task automatic train(input logic [31:0] upc, input logic tk, input logic [31:0] tgt);
        bif.update        = 1'b1;
        bif.update_pc     = upc;
        bif.update_taken  = tk;
        bif.update_target = tgt;
        edge1();
        bif.update = 1'b0;
    endtask

    task automatic look(input logic [31:0] lpc, input string tag, input logic v,
                        input logic pt, input logic [31:0] tgt);
        bif.pc = lpc;
        #1;
        chk({tag, ".valid"}, 32'(bif.valid), 32'(v));
        chk({tag, ".taken"}, 32'(bif.predicted_taken), 32'(pt));
        chk({tag, ".target"}, bif.target_pc, tgt);
    endtask

    task automatic counts(input string tag, input int lc, input int hc);
        #1;
        chk({tag, ".lookups"}, 32'(bif.lookup_count), 32'(lc));
        chk({tag, ".hits"}, 32'(bif.hit_count), 32'(hc));
    endtask

    initial begin
        bif.pc = 32'h100; bif.lookup_en = 1'b0; bif.update = 1'b0;
        bif.update_pc = '0; bif.update_taken = 1'b0; bif.update_target = '0;
        bif.flush_all = 1'b0; bif.perf_clear = 1'b0;

        #2;
        look(32'h100, "reset", 1'b0, 1'b0, 32'h0);
        counts("reset", 0, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        edge1();

        // Allocation; same-cycle lookup sees pre-update contents.
        bif.update = 1'b1; bif.update_pc = 32'h100;
        bif.update_taken = 1'b1; bif.update_target = 32'h200;
        look(32'h100, "pre_update", 1'b0, 1'b0, 32'h0);
        edge1();
        bif.update = 1'b0;
        look(32'h100, "alloc", 1'b1, 1'b1, 32'h200);
        look(32'h140, "alias_miss", 1'b0, 1'b0, 32'h0);

        // ctr 2 -> 3, saturates, then decrements.
        repeat (3) train(32'h100, 1'b1, 32'h200);
        train(32'h100, 1'b0, 32'hdead);
        look(32'h100, "nt1", 1'b1, 1'b1, 32'h200);
        train(32'h100, 1'b0, 32'hdead);
        look(32'h100, "nt2", 1'b1, 1'b0, 32'h200);
        repeat (2) train(32'h100, 1'b0, 32'hdead);
        look(32'h100, "floor", 1'b1, 1'b0, 32'h200);
        // From 0, one taken gives 1: still predicted not-taken, target replaced.
        train(32'h100, 1'b1, 32'h280);
        look(32'h100, "from_zero", 1'b1, 1'b0, 32'h280);

        train(32'h300, 1'b0, 32'h111);
        look(32'h300, "nt_noalloc", 1'b0, 1'b0, 32'h0);
        train(32'h140, 1'b0, 32'h111);
        look(32'h100, "nt_noevict", 1'b1, 1'b0, 32'h280);
        look(32'h140, "nt_alias", 1'b0, 1'b0, 32'h0);

        // Flush beats a simultaneous taken update.
        bif.flush_all = 1'b1;
        train(32'h400, 1'b1, 32'h444);
        bif.flush_all = 1'b0;
        look(32'h100, "flush_100", 1'b0, 1'b0, 32'h0);
        look(32'h400, "flush_400", 1'b0, 1'b0, 32'h0);

        // Taken aliasing replaces the resident entry.
        train(32'h140, 1'b1, 32'h500);
        look(32'h140, "alias_alloc", 1'b1, 1'b1, 32'h500);
        train(32'h100, 1'b1, 32'h600);
        look(32'h100, "alias_repl", 1'b1, 1'b1, 32'h600);
        look(32'h140, "alias_evicted", 1'b0, 1'b0, 32'h0);
        counts("idle", 0, 0);

        // Perf counters.
        bif.pc = 32'h100; bif.lookup_en = 1'b1;
        repeat (10) edge1();
        counts("perf10", 10, 10);
        bif.pc = 32'h140;
        repeat (5) edge1();
        counts("perf15", 15, 10);
        bif.pc = 32'h100;
        repeat (300) edge1();
        counts("perf_sat", 255, 255);
        bif.perf_clear = 1'b1;
        edge1();
        bif.perf_clear = 1'b0;
        counts("perf_clear", 0, 0);
        edge1();
        bif.lookup_en = 1'b0;
        counts("perf_after", 1, 1);
        bif.flush_all = 1'b1;
        edge1();
        bif.flush_all = 1'b0;
        counts("perf_flush", 1, 1);
        look(32'h100, "post_flush", 1'b0, 1'b0, 32'h0);

        // Mid-training reset, then normal operation resumes.
        train(32'h100, 1'b1, 32'h700);
        look(32'h100, "pre_rst", 1'b1, 1'b1, 32'h700);
        #2 rst = 1'b1;
        look(32'h100, "async_rst", 1'b0, 1'b0, 32'h0);
        counts("async_rst", 0, 0);
        @(negedge clk);
        rst = 1'b0;
        edge1();
        train(32'h100, 1'b1, 32'h800);
        look(32'h100, "post_rst", 1'b1, 1'b1, 32'h800);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
